// File: rtl/tank_ctrl.sv
// Per-player tank controller: turns scancodes into position, facing, shield and respawn state.
// All state advances once per frame_clk rising edge.
module tank_ctrl #(
  parameter int unsigned X_SPAWN         = 120,
  parameter int unsigned Y_SPAWN         = 240,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 639,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 479,
  parameter int unsigned SIZE            = 16,
  parameter int unsigned STEP            = 1,
  parameter int unsigned N_OBS           = 13,
  parameter int unsigned SHIELD_FRAMES   = 120,
  parameter int unsigned SHIELD_COOLDOWN = 240,
  parameter int unsigned RESPAWN_FRAMES  = 60,
  parameter logic [7:0]  KEY_UP          = 8'h1A,
  parameter logic [7:0]  KEY_DOWN        = 8'h16,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_SHIELD      = 8'h09
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [3*N_OBS-1:0] bounce_on,
  input  logic               game_over,
  input  logic               shot_hit,
  output logic [9:0]         TankX,
  output logic [9:0]         TankY,
  output logic [9:0]         TankS,
  output logic [2:0]         rotation,
  output logic               field_on,
  output logic               shield_ready,
  output logic               respawning,
  output logic [3:0]         deaths
);

  typedef enum logic [1:0] {StAlive, StRespawn, StFrozen} state_e;

  localparam int unsigned ShW = (SHIELD_FRAMES > 1) ? $clog2(SHIELD_FRAMES) : 1;
  localparam int unsigned CoW = (SHIELD_COOLDOWN > 1) ? $clog2(SHIELD_COOLDOWN) : 1;
  localparam int unsigned ReW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  // Far-edge offset of a stepped sprite, and the lowest coordinate a step toward 0 may start from.
  localparam logic [10:0] FarOff = 11'(STEP + SIZE - 1);
  localparam logic [10:0] XLoLim = 11'(X_MIN + STEP);
  localparam logic [10:0] YLoLim = 11'(Y_MIN + STEP);
  localparam logic [10:0] XHi    = 11'(X_MAX);
  localparam logic [10:0] YHi    = 11'(Y_MAX);
  localparam logic [9:0]  XSp    = 10'(X_SPAWN);
  localparam logic [9:0]  YSp    = 10'(Y_SPAWN);
  localparam logic [9:0]  Step10 = 10'(STEP);

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       rot_q, rot_d;
  logic             field_q, field_d, ready_q, ready_d;
  logic [ShW-1:0]   shield_cnt_q, shield_cnt_d;
  logic [CoW-1:0]   cool_cnt_q, cool_cnt_d;
  logic [ReW-1:0]   resp_cnt_q, resp_cnt_d;
  logic [3:0]       deaths_q, deaths_d;
  logic [3:0]       blk;

  // blk[c] is set when any obstacle channel reports contact code c.
  always_comb begin
    blk = 4'b0000;
    for (int i = 0; i < N_OBS; i++) begin
      if (!bounce_on[3*i+2]) blk[bounce_on[3*i +: 2]] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    rot_d        = rot_q;
    field_d      = field_q;
    ready_d      = ready_q;
    shield_cnt_d = shield_cnt_q;
    cool_cnt_d   = cool_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    deaths_d     = deaths_q;

    if (!game_over && state_q != StFrozen && !ready_q && !field_q) begin
      if (cool_cnt_q == '0) ready_d = 1'b1;
      else                  cool_cnt_d = cool_cnt_q - CoW'(1);
    end

    if (game_over) begin
      state_d      = StFrozen;
      x_d          = XSp;
      y_d          = YSp;
      rot_d        = 3'b000;
      field_d      = 1'b0;
      ready_d      = 1'b1;
      shield_cnt_d = '0;
      cool_cnt_d   = '0;
      resp_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StFrozen: state_d = StAlive;
        StRespawn: begin
          if (resp_cnt_q == '0) state_d = StAlive;
          else                  resp_cnt_d = resp_cnt_q - ReW'(1);
        end
        StAlive: begin
          if (shot_hit && !field_q) begin
            state_d    = StRespawn;
            x_d        = XSp;
            y_d        = YSp;
            rot_d      = 3'b000;
            resp_cnt_d = ReW'(RESPAWN_FRAMES - 1);
            if (deaths_q != 4'hF) deaths_d = deaths_q + 4'd1;
          end else if (field_q) begin
            if (keycode != KEY_SHIELD || shield_cnt_q == '0) begin
              field_d    = 1'b0;
              ready_d    = 1'b0;
              cool_cnt_d = CoW'(SHIELD_COOLDOWN - 1);
            end else begin
              shield_cnt_d = shield_cnt_q - ShW'(1);
            end
          end else if (keycode == KEY_SHIELD && ready_q) begin
            field_d      = 1'b1;
            shield_cnt_d = ShW'(SHIELD_FRAMES - 1);
          end else if (keycode == KEY_RIGHT) begin
            rot_d = 3'b000;
            if ({1'b0, x_q} + FarOff <= XHi && !blk[0]) x_d = x_q + Step10;
          end else if (keycode == KEY_LEFT) begin
            rot_d = 3'b001;
            if ({1'b0, x_q} >= XLoLim && !blk[1]) x_d = x_q - Step10;
          end else if (keycode == KEY_DOWN) begin
            rot_d = 3'b010;
            if ({1'b0, y_q} + FarOff <= YHi && !blk[2]) y_d = y_q + Step10;
          end else if (keycode == KEY_UP) begin
            rot_d = 3'b011;
            if ({1'b0, y_q} >= YLoLim && !blk[3]) y_d = y_q - Step10;
          end
        end
        default: state_d = StAlive;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= StAlive;
      x_q          <= XSp;
      y_q          <= YSp;
      rot_q        <= 3'b000;
      field_q      <= 1'b0;
      ready_q      <= 1'b1;
      shield_cnt_q <= '0;
      cool_cnt_q   <= '0;
      resp_cnt_q   <= '0;
      deaths_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rot_q        <= rot_d;
      field_q      <= field_d;
      ready_q      <= ready_d;
      shield_cnt_q <= shield_cnt_d;
      cool_cnt_q   <= cool_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      deaths_q     <= deaths_d;
    end
  end

  assign TankX        = x_q;
  assign TankY        = y_q;
  assign TankS        = 10'(SIZE);
  assign rotation     = rot_q;
  assign field_on     = field_q;
  assign shield_ready = ready_q;
  assign respawning   = (state_q == StRespawn);
  assign deaths       = deaths_q;

endmodule
